johnson_phase_decoder: RTL and testbench

Consumes the N-bit twisted-ring (Johnson) count produced by the ring-counter stage. Each sample is decoded into a one-hot phase strobe and a binary phase index. The block checks every sample for code legality and correct succession, tracks lock with a small state machine, and counts completed counter cycles and errors. It sits directly downstream of the counter and feeds phase-sequenced logic.

---
 rtl/johnson_phase_decoder_if.sv | 33 +++
 rtl/johnson_phase_decoder.sv | 177 +++++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/johnson_phase_decoder_if.sv
// Bus between the Johnson counter stage, this decoder and the phase-sequenced logic.
// The upstream side (master) drives count_in/cnt_valid; the decoder (slave) drives everything else.
interface johnson_phase_decoder_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(2 * N);

    logic [N-1:0]   count_in;
    logic           cnt_valid;
    logic [2*N-1:0] phase_onehot;
    logic [IW-1:0]  phase_idx;
    logic           phase_valid;
    logic           illegal;
    logic           seq_err;
    logic           wrap_pulse;
    logic           lock;
    logic [15:0]    cycle_cnt;
    logic [7:0]     err_cnt;
    logic           dbg_state;
    logic [3:0]     dbg_good_run;

    modport master (
        output count_in, cnt_valid,
        input  phase_onehot, phase_idx, phase_valid, illegal, seq_err,
               wrap_pulse, lock, cycle_cnt, err_cnt, dbg_state, dbg_good_run
    );

    modport slave (
        input  count_in, cnt_valid,
        output phase_onehot, phase_idx, phase_valid, illegal, seq_err,
               wrap_pulse, lock, cycle_cnt, err_cnt, dbg_state, dbg_good_run
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes a twisted-ring (Johnson) count into one-hot/binary phase, checks legality and
// succession, tracks lock, and counts completed cycles and errors. All outputs registered.
module johnson_phase_decoder #(
    parameter int N          = 4,
    parameter int LOCK_LEN   = 4,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    johnson_phase_decoder_if.slave bus
);
    localparam int IW = $clog2(2 * N);
    localparam int PW = IW + 1;
    localparam logic [N-1:0]   N_ONE  = N'(1);
    localparam logic [2*N-1:0] OH_ONE = (2 * N)'(1);
    localparam logic [PW-1:0]  TWO_N  = PW'(2 * N);
    localparam logic [4:0]     LOCK_TARGET = 5'(LOCK_LEN);

    typedef enum logic {ST_ACQ = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_lock;

    logic [N-1:0]   r_prev_code;
    logic           r_have_prev;
    logic [3:0]     r_good_run;
    logic [2*N-1:0] r_phase_onehot;
    logic [IW-1:0]  r_phase_idx;
    logic           r_phase_valid;
    logic           r_illegal;
    logic           r_seq_err;
    logic           r_wrap_pulse;
    logic [15:0]    r_cycle_cnt;
    logic [7:0]     r_err_cnt;

    logic [N-1:0]   w_code;
    logic [N-1:0]   w_inv;
    logic [N-1:0]   w_succ;
    logic           w_legal;
    logic [PW-1:0]  w_pop;
    logic [IW-1:0]  w_idx;
    logic [2*N-1:0] w_onehot;
    logic           w_hold;
    logic           w_check;
    logic           w_good;
    logic           w_seq_err;
    logic           w_err;
    logic           w_wrap;
    logic [4:0]     w_run_plus1;

    assign w_code = bus.count_in;
    assign w_inv  = ~w_code;
    assign w_succ = {~r_prev_code[0], r_prev_code[N-1:1]};

    // Ones contiguous from the MSB means the complement is a low-anchored run (x & (x+1) == 0).
    assign w_legal = w_code[N-1] ? ((w_inv & (w_inv + N_ONE)) == '0)
                                 : ((w_code & (w_code + N_ONE)) == '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + PW'(w_code[i]);
        end
        if (w_code == '0) begin
            w_idx = '0;
        end else if (w_code[N-1]) begin
            w_idx = IW'(w_pop);
        end else begin
            w_idx = IW'(TWO_N - w_pop);
        end
        w_onehot = OH_ONE << w_idx;
    end

    // A repeated code is a stall only when holds are allowed; it then neither counts nor errs.
    assign w_hold    = (ALLOW_HOLD != 0) && w_legal && r_have_prev && (w_code == r_prev_code);
    assign w_check   = bus.cnt_valid && w_legal && r_have_prev && !w_hold;
    assign w_good    = w_check && (w_code == w_succ);
    assign w_seq_err = w_check && (w_code != w_succ);
    assign w_err     = (bus.cnt_valid && !w_legal) || w_seq_err;
    // The only good successor that lands on index 0 is the all-zeros code after index 2N-1.
    assign w_wrap    = w_good && (w_code == '0);
    assign w_run_plus1 = {1'b0, r_good_run} + 5'd1;

    // Lock FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lock FSM: next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACQ: begin
                if (w_good && (w_run_plus1 >= LOCK_TARGET)) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_err) begin
                    w_state_next = ST_ACQ;
                end
            end
            default: w_state_next = ST_ACQ;
        endcase
    end

    // Lock FSM: outputs.
    always_comb begin
        w_lock = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_lock = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_code    <= '0;
            r_have_prev    <= 1'b0;
            r_good_run     <= '0;
            r_phase_onehot <= '0;
            r_phase_idx    <= '0;
            r_phase_valid  <= 1'b0;
            r_illegal      <= 1'b0;
            r_seq_err      <= 1'b0;
            r_wrap_pulse   <= 1'b0;
            r_cycle_cnt    <= '0;
            r_err_cnt      <= '0;
        end else if (bus.cnt_valid) begin
            if (w_legal) begin
                r_prev_code    <= w_code;
                r_have_prev    <= 1'b1;
                r_phase_onehot <= w_onehot;
                r_phase_idx    <= w_idx;
                r_phase_valid  <= 1'b1;
            end else begin
                r_have_prev    <= 1'b0;
                r_phase_onehot <= '0;
                r_phase_valid  <= 1'b0;
            end
            r_illegal    <= !w_legal;
            r_seq_err    <= w_seq_err;
            r_wrap_pulse <= w_wrap;
            if (w_wrap && (r_cycle_cnt != 16'hFFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_err) begin
                r_good_run <= '0;
            end else if (w_good && (r_good_run != 4'hF)) begin
                r_good_run <= r_good_run + 4'd1;
            end
        end else begin
            r_illegal    <= 1'b0;
            r_seq_err    <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end
    end

    assign bus.phase_onehot = r_phase_onehot;
    assign bus.phase_idx    = r_phase_idx;
    assign bus.phase_valid  = r_phase_valid;
    assign bus.illegal      = r_illegal;
    assign bus.seq_err      = r_seq_err;
    assign bus.wrap_pulse   = r_wrap_pulse;
    assign bus.lock         = w_lock;
    assign bus.cycle_cnt    = r_cycle_cnt;
    assign bus.err_cnt      = r_err_cnt;
    assign bus.dbg_state    = r_state;
    assign bus.dbg_good_run = r_good_run;
endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder (N=4, LOCK_LEN=4); a second instance with
// ALLOW_HOLD=1 sees the same stimulus and is checked where stall behaviour differs.
module tb_johnson_phase_decoder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    johnson_phase_decoder_if #(.N(4)) b0 ();
    johnson_phase_decoder_if #(.N(4)) b1 ();

    johnson_phase_decoder #(.N(4), .LOCK_LEN(4), .ALLOW_HOLD(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    johnson_phase_decoder #(.N(4), .LOCK_LEN(4), .ALLOW_HOLD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-written Johnson codes indexed by phase.
    logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] c);
        @(negedge clk);
        rst          = r;
        b0.cnt_valid = v;
        b0.count_in  = c;
        b1.cnt_valid = v;
        b1.count_in  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_onehot"}, 32'(b0.phase_onehot), 32'h0);
        chk({tag, "_idx"},    32'(b0.phase_idx),    32'h0);
        chk({tag, "_valid"},  32'(b0.phase_valid),  32'h0);
        chk({tag, "_pulses"}, {29'd0, b0.illegal, b0.seq_err, b0.wrap_pulse}, 32'h0);
        chk({tag, "_lock"},   32'(b0.lock),         32'h0);
        chk({tag, "_cycle"},  32'(b0.cycle_cnt),    32'h0);
        chk({tag, "_err"},    32'(b0.err_cnt),      32'h0);
        chk({tag, "_lock1"},  32'(b1.lock),         32'h0);
    endtask

    initial begin
        int p;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        b0.cnt_valid = 1'b0; b0.count_in = '0;
        b1.cnt_valid = 1'b0; b1.count_in = '0;

        // Reset overrides a valid sample.
        drive(1'b1, 1'b1, 4'b1111);
        drive(1'b1, 1'b1, 4'b1111);
        chk_zero("reset");

        // Reset then run 20 samples from 0001 (phase 7).
        for (int k = 0; k < 20; k++) begin
            p = (7 + k) % 8;
            drive(1'b0, 1'b1, codes[p]);
            chk($sformatf("run_idx%0d", k), 32'(b0.phase_idx), 32'(p));
            chk($sformatf("run_seq%0d", k), {30'd0, b0.seq_err, b0.illegal}, 32'h0);
            if (k == 0) begin
                chk("first_onehot", 32'(b0.phase_onehot), 32'h80);
                chk("first_valid",  32'(b0.phase_valid),  32'h1);
                chk("first_wrap",   32'(b0.wrap_pulse),   32'h0);
                chk("first_lock",   32'(b0.lock),         32'h0);
            end
            if (k == 1) begin
                chk("second_wrap",  32'(b0.wrap_pulse), 32'h1);
                chk("second_cycle", 32'(b0.cycle_cnt),  32'h1);
            end
            if (k == 3) chk("lock_after_3_good", 32'(b0.lock), 32'h0);
            if (k == 4) chk("lock_after_4_good", 32'(b0.lock), 32'h1);
        end
        chk("run_cycle_cnt", 32'(b0.cycle_cnt), 32'h3);
        chk("run_err_cnt",   32'(b0.err_cnt),   32'h0);

        // Illegal code while locked; last legal phase was 2.
        drive(1'b0, 1'b1, 4'b0101);
        chk("ill_pulse",  32'(b0.illegal),      32'h1);
        chk("ill_seq",    32'(b0.seq_err),      32'h0);
        chk("ill_valid",  32'(b0.phase_valid),  32'h0);
        chk("ill_onehot", 32'(b0.phase_onehot), 32'h0);
        chk("ill_idx",    32'(b0.phase_idx),    32'h2);
        chk("ill_lock",   32'(b0.lock),         32'h0);
        chk("ill_err",    32'(b0.err_cnt),      32'h1);
        drive(1'b0, 1'b1, 4'b1110);
        chk("post_ill_unchecked", {30'd0, b0.seq_err, b0.illegal}, 32'h0);
        chk("post_ill_idx",       32'(b0.phase_idx), 32'h3);
        drive(1'b0, 1'b1, 4'b1111);
        drive(1'b0, 1'b1, 4'b0111);
        drive(1'b0, 1'b1, 4'b0011);
        chk("relock_3_good", 32'(b0.lock), 32'h0);
        drive(1'b0, 1'b1, 4'b0001);
        chk("relock_4_good", 32'(b0.lock), 32'h1);

        // Skipped phase 1100 -> 1111.
        drive(1'b0, 1'b1, 4'b0000);
        chk("skip_pre_cycle", 32'(b0.cycle_cnt), 32'h4);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b1100);
        drive(1'b0, 1'b1, 4'b1111);
        chk("skip_seq",  32'(b0.seq_err),   32'h1);
        chk("skip_ill",  32'(b0.illegal),   32'h0);
        chk("skip_lock", 32'(b0.lock),      32'h0);
        chk("skip_err",  32'(b0.err_cnt),   32'h2);
        chk("skip_idx",  32'(b0.phase_idx), 32'h4);

        // Relock, then stall on 1110.
        drive(1'b0, 1'b1, 4'b0111);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0000);
        chk("stall_pre_lock", 32'(b0.lock), 32'h1);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b1100);
        drive(1'b0, 1'b1, 4'b1110);
        drive(1'b0, 1'b1, 4'b1110);
        chk("stall0_seq",  32'(b0.seq_err), 32'h1);
        chk("stall0_lock", 32'(b0.lock),    32'h0);
        chk("stall0_err",  32'(b0.err_cnt), 32'h3);
        chk("stall1_seq",  32'(b1.seq_err), 32'h0);
        chk("stall1_lock", 32'(b1.lock),    32'h1);
        chk("stall1_err",  32'(b1.err_cnt), 32'h2);
        chk("stall1_idx",  32'(b1.phase_idx), 32'h3);
        drive(1'b0, 1'b1, 4'b1111);
        chk("post_stall0_seq", 32'(b0.seq_err), 32'h0);
        chk("post_stall1_seq", 32'(b1.seq_err), 32'h0);

        // cnt_valid gaps: garbage on count_in must be ignored.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 4'b0101);
            chk($sformatf("gap_idx%0d", k),    32'(b0.phase_idx),    32'h4);
            chk($sformatf("gap_onehot%0d", k), 32'(b0.phase_onehot), 32'h10);
            chk($sformatf("gap_valid%0d", k),  32'(b0.phase_valid),  32'h1);
            chk($sformatf("gap_pulses%0d", k), {29'd0, b0.illegal, b0.seq_err, b0.wrap_pulse}, 32'h0);
            chk($sformatf("gap_err%0d", k),    32'(b0.err_cnt),      32'h3);
        end
        drive(1'b0, 1'b1, 4'b0111);
        chk("gap_resume_seq", {30'd0, b0.seq_err, b0.illegal}, 32'h0);
        chk("gap_resume_idx", 32'(b0.phase_idx), 32'h5);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0001);
        chk("gap_relock", 32'(b0.lock), 32'h1);

        // One-cycle reset while locked.
        drive(1'b1, 1'b1, 4'b0000);
        chk_zero("midreset");

        // err_cnt saturation: 254 illegal samples reach FE, then 3 more.
        for (int k = 0; k < 254; k++) begin
            drive(1'b0, 1'b1, 4'b0101);
        end
        chk("sat_pre", 32'(b0.err_cnt), 32'hFE);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 4'b1010);
            chk($sformatf("sat_ill%0d", k), 32'(b0.illegal), 32'h1);
            chk($sformatf("sat_err%0d", k), 32'(b0.err_cnt), 32'hFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
